// File: rtl/riscv_test_monitor_pkg.sv
// Shared types and constants for the riscv-tests completion monitor.
package riscv_test_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    typedef enum logic [2:0] {
        V_NONE,
        V_PASS,
        V_FAIL,
        V_TIMEOUT,
        V_HANG
    } verdict_t;

    localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;
    localparam int          TOHOST_PASS     = 1;
endpackage

// File: rtl/riscv_test_monitor_if.sv
// Snooped data-memory write bus plus the retire strobe of the core under test.
interface riscv_test_monitor_if #(
    parameter int XLEN = 32
) ();
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            retire;

    modport master (output mem_we, mem_addr, mem_wdata, retire);
    modport slave  (input  mem_we, mem_addr, mem_wdata, retire);
endinterface

// File: rtl/riscv_test_trace_ring.sv
// Eight-deep ring of the most recently retired PCs, read newest-first by index.
module riscv_test_trace_ring #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clr,
    input  logic            i_we,
    input  logic [XLEN-1:0] i_pc,
    input  logic [2:0]      i_idx,
    output logic [XLEN-1:0] o_rd_pc
);
    logic [7:0][XLEN-1:0] r_mem;
    logic [2:0]           r_wptr;
    logic [2:0]           w_rd_idx;

    // Entries are zeroed on clear so slots never written read back as 0.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_mem  <= '0;
            r_wptr <= '0;
        end else if (i_we) begin
            r_mem[r_wptr] <= i_pc;
            r_wptr        <= r_wptr + 3'd1;
        end
    end

    always_comb begin
        w_rd_idx = r_wptr - 3'd1 - i_idx;
        o_rd_pc  = r_mem[w_rd_idx];
    end
endmodule

// File: rtl/riscv_test_monitor.sv
// Completion monitor for riscv-tests programs: watches tohost, counts, latches a verdict.
// Define RISCV_TEST_MONITOR_TRACE_EN to add the retired-PC trace ring and its ports.
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(TOHOST_ADDR_DEF),
    parameter int              TIMEOUT_CYCLES = 5000,
    parameter int              HANG_CYCLES    = 64,
    parameter int              CNT_W          = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    riscv_test_monitor_if.slave bus,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_fail,
    output logic              o_timeout,
    output logic              o_hang,
    output logic [XLEN-2:0]   o_fail_testnum,
    output logic [CNT_W-1:0]  o_cycle_count,
    output logic [CNT_W-1:0]  o_instret_count,
    output logic [7:0]        o_syscall_count
`ifdef RISCV_TEST_MONITOR_TRACE_EN
    ,
    input  logic [XLEN-1:0]   i_trace_pc,
    input  logic [2:0]        i_trace_idx,
    output logic [XLEN-1:0]   o_trace_rd_pc
`endif
);
    state_t           r_state, w_state_nxt;
    verdict_t         r_verdict, w_verdict_nxt;
    logic [CNT_W-1:0] r_cycle, r_instret, r_hang_cnt;
    logic [7:0]       r_syscall;
    logic [XLEN-2:0]  r_testnum;

    logic w_match, w_is_pass, w_is_fail, w_is_sys, w_hang_hit, w_to_hit;

    always_comb begin
        w_match    = bus.mem_we && (bus.mem_addr == TOHOST_ADDR);
        w_is_pass  = w_match && (bus.mem_wdata == XLEN'(TOHOST_PASS));
        w_is_fail  = w_match && bus.mem_wdata[0] && (bus.mem_wdata != XLEN'(TOHOST_PASS));
        w_is_sys   = w_match && !bus.mem_wdata[0] && (bus.mem_wdata != '0);
        // Fire on the edge that completes the Nth count so exactly N cycles elapse.
        w_hang_hit = (HANG_CYCLES != 0) && !bus.retire &&
                     (r_hang_cnt == CNT_W'(HANG_CYCLES - 1));
        w_to_hit   = (TIMEOUT_CYCLES != 0) && (r_cycle == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_verdict_nxt = r_verdict;
        if (i_start) begin
            w_state_nxt   = S_RUN;
            w_verdict_nxt = V_NONE;
        end else if (r_state == S_RUN) begin
            if (w_is_pass) begin
                w_state_nxt   = S_DONE;
                w_verdict_nxt = V_PASS;
            end else if (w_is_fail) begin
                w_state_nxt   = S_DONE;
                w_verdict_nxt = V_FAIL;
            end else if (w_hang_hit) begin
                w_state_nxt   = S_DONE;
                w_verdict_nxt = V_HANG;
            end else if (w_to_hit) begin
                w_state_nxt   = S_DONE;
                w_verdict_nxt = V_TIMEOUT;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_verdict <= V_NONE;
        end else begin
            r_state   <= w_state_nxt;
            r_verdict <= w_verdict_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_start) begin
            r_cycle    <= '0;
            r_instret  <= '0;
            r_hang_cnt <= '0;
            r_syscall  <= '0;
            r_testnum  <= '0;
        end else if (r_state == S_RUN) begin
            if (r_cycle != '1)
                r_cycle <= r_cycle + 1'b1;
            if (bus.retire && r_instret != '1)
                r_instret <= r_instret + 1'b1;
            r_hang_cnt <= bus.retire ? '0 : r_hang_cnt + 1'b1;
            if (w_is_sys && r_syscall != 8'hFF)
                r_syscall <= r_syscall + 8'd1;
            if (w_is_fail)
                r_testnum <= bus.mem_wdata[XLEN-1:1];
        end
    end

    always_comb begin
        o_done          = (r_state == S_DONE);
        o_pass          = (r_verdict == V_PASS);
        o_fail          = (r_verdict == V_FAIL);
        o_timeout       = (r_verdict == V_TIMEOUT);
        o_hang          = (r_verdict == V_HANG);
        o_fail_testnum  = r_testnum;
        o_cycle_count   = r_cycle;
        o_instret_count = r_instret;
        o_syscall_count = r_syscall;
    end

`ifdef RISCV_TEST_MONITOR_TRACE_EN
    riscv_test_trace_ring #(.XLEN(XLEN)) u_ring (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (i_start),
        .i_we    ((r_state == S_RUN) && bus.retire && !i_start),
        .i_pc    (i_trace_pc),
        .i_idx   (i_trace_idx),
        .o_rd_pc (o_trace_rd_pc)
    );
`endif
endmodule
